// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: the head entry is always visible on pop_data.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // A push into a full FIFO is allowed when the head leaves in the same cycle.
  assign do_push  = push && (!full || pop);
  assign do_pop   = pop && !empty;
  assign full     = (count == CNTW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= push_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, optional parity and a FWFT
// receive FIFO carrying a parity-error tag per word.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            rx_in,
  input  logic [1:0]                      cfg_parity,
  output logic [DATA_BITS-1:0]            rx_data,
  output logic                            rx_perr,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            frame_err,
  output logic                            overrun_err,
  input  logic                            err_clr,
  output logic                            busy
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_BITS);

  if (CLKS_PER_BIT < 8) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be at least 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("DATA_BITS must be in 5..9");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  logic                 rx_meta, rx_s;
  rx_state_e            state;
  parity_e              par_mode;
  logic [CW-1:0]        clk_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 s0, s1, perr;
  logic                 vote, at_vote, at_end;
  logic                 pop, push, stop_dec, frame_set, ovr_set;
  logic                 fifo_full, fifo_empty;
  logic [DATA_BITS:0]   fifo_dout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  // Third sample is taken live at HALF+1 and voted with the two stored ones.
  assign vote    = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign at_vote = (clk_cnt == CW'(HALF + 1));
  assign at_end  = (clk_cnt == CW'(CLKS_PER_BIT - 1));

  assign pop       = rx_valid && rx_ready;
  assign stop_dec  = (state == STOP) && at_vote;
  assign push      = stop_dec && vote && (!fifo_full || pop);
  assign frame_set = stop_dec && !vote;
  assign ovr_set   = stop_dec && vote && fifo_full && !pop;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      par_mode <= PAR_NONE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      s0       <= 1'b1;
      s1       <= 1'b1;
      perr     <= 1'b0;
    end else begin
      if (clk_cnt == CW'(HALF - 1)) s0 <= rx_s;
      if (clk_cnt == CW'(HALF))     s1 <= rx_s;
      case (state)
        IDLE: if (!rx_s) begin
          state    <= START;
          clk_cnt  <= '0;
          perr     <= 1'b0;
          par_mode <= (cfg_parity == 2'b11) ? PAR_NONE : parity_e'(cfg_parity);
        end
        START: begin
          clk_cnt <= clk_cnt + CW'(1);
          if (at_vote && vote) begin
            state   <= IDLE;
            clk_cnt <= '0;
          end else if (at_end) begin
            state   <= DATA;
            clk_cnt <= '0;
            bit_idx <= '0;
          end
        end
        DATA: begin
          clk_cnt <= clk_cnt + CW'(1);
          if (at_vote) shreg[bit_idx] <= vote;
          if (at_end) begin
            clk_cnt <= '0;
            if (bit_idx == BW'(DATA_BITS - 1))
              state <= (par_mode == PAR_NONE) ? STOP : PARITY;
            else
              bit_idx <= bit_idx + BW'(1);
          end
        end
        PARITY: begin
          clk_cnt <= clk_cnt + CW'(1);
          // Odd mode expects the complement of the data XOR.
          if (at_vote) perr <= vote ^ (^shreg) ^ (par_mode == PAR_ODD);
          if (at_end) begin
            state   <= STOP;
            clk_cnt <= '0;
          end
        end
        STOP: begin
          clk_cnt <= clk_cnt + CW'(1);
          // Deciding mid stop bit lets a back-to-back start edge be seen early.
          if (at_vote) begin
            state   <= IDLE;
            clk_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (frame_set)    frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (ovr_set)      overrun_err <= 1'b1;
      else if (err_clr) overrun_err <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (push),
    .push_data ({perr, shreg}),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rx_valid = !fifo_empty;
  assign rx_data  = fifo_dout[DATA_BITS-1:0];
  assign rx_perr  = fifo_dout[DATA_BITS];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at default parameters (20 ns clock).
module tb_uart_rx_fifo;
  localparam int CPB = 434;

  logic       clk = 1'b0;
  logic       reset, rx_in, rx_ready, err_clr;
  logic [1:0] cfg_parity;
  logic [7:0] rx_data;
  logic       rx_perr, rx_valid, frame_err, overrun_err, busy;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;
  logic [8:0] popq[$];

  always #10 clk = ~clk;

  uart_rx_fifo dut (
    .clk (clk), .reset (reset), .rx_in (rx_in), .cfg_parity (cfg_parity),
    .rx_data (rx_data), .rx_perr (rx_perr), .rx_valid (rx_valid),
    .rx_ready (rx_ready), .fifo_count (fifo_count), .frame_err (frame_err),
    .overrun_err (overrun_err), .err_clr (err_clr), .busy (busy)
  );

  // Record every popped {perr, data} word.
  always @(posedge clk)
    if (!reset && rx_valid && rx_ready) popq.push_back({rx_perr, rx_data});

  task automatic bit_time(input logic v, input int n);
    rx_in = v;
    repeat (n) @(negedge clk);
  endtask

  // par_bit < 0 means no parity bit; rdy_stop raises rx_ready before the stop bit.
  task automatic send_frame(input logic [7:0] d, input int par_bit,
                            input logic stop_bit, input bit rdy_stop);
    bit_time(1'b0, CPB);
    for (int i = 0; i < 8; i++) bit_time(d[i], CPB);
    if (par_bit >= 0) bit_time(par_bit[0], CPB);
    if (rdy_stop) rx_ready = 1'b1;
    bit_time(stop_bit, CPB);
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    for (int i = 0; i < 20 && rx_valid; i++) @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL drain_timeout got valid=%b exp 0", rx_valid); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if ({rx_valid, rx_data, rx_perr} !== 10'h0) begin errors++; $display("FAIL reset_out got %b/%h/%b exp 0/00/0", rx_valid, rx_data, rx_perr); end
    checks++; if ({fifo_count, frame_err, overrun_err, busy} !== 6'h0) begin errors++; $display("FAIL reset_status got cnt=%0d fe=%b oe=%b busy=%b exp all 0", fifo_count, frame_err, overrun_err, busy); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    popq.delete();
    send_frame(8'hA5, -1, 1'b1, 1'b0);
    send_frame(8'hFF, -1, 1'b1, 1'b0);
    send_frame(8'h00, -1, 1'b1, 1'b0);
    bit_time(1'b1, 4);
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL basic_count got %0d exp 3", fifo_count); end
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin errors++; $display("FAIL basic_head got %b/%h exp 1/a5", rx_valid, rx_data); end
    drain();
    checks++; if (popq.size() !== 3) begin errors++; $display("FAIL basic_npop got %0d exp 3", popq.size()); end
    else if (popq[0] !== 9'h0A5 || popq[1] !== 9'h0FF || popq[2] !== 9'h000) begin errors++; $display("FAIL basic_data got %h %h %h exp 0a5 0ff 000", popq[0], popq[1], popq[2]); end
    checks++; if ({frame_err, overrun_err} !== 2'b00) begin errors++; $display("FAIL basic_flags got %b%b exp 00", frame_err, overrun_err); end
  endtask

  task automatic test_glitch();
    bit_time(1'b0, 108);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_hi got %b exp 1", busy); end
    bit_time(1'b1, CPB);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_lo got %b exp 0", busy); end
    bit_time(1'b1, CPB);
    checks++; if ({fifo_count, frame_err, overrun_err} !== 5'h0) begin errors++; $display("FAIL glitch_state got cnt=%0d fe=%b oe=%b exp 0", fifo_count, frame_err, overrun_err); end
  endtask

  task automatic test_framing();
    popq.delete();
    send_frame(8'hFF, -1, 1'b0, 1'b0);
    bit_time(1'b1, CPB);
    send_frame(8'h3C, -1, 1'b1, 1'b0);
    bit_time(1'b1, 4);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL frame_set got %b exp 1", frame_err); end
    checks++; if (fifo_count !== 3'd1 || rx_data !== 8'h3C) begin errors++; $display("FAIL frame_fifo got cnt=%0d data=%h exp 1/3c", fifo_count, rx_data); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL frame_clr got %b exp 0", frame_err); end
    drain();
  endtask

  task automatic test_parity();
    // 0x07 has odd weight: even mode expects 1, odd mode expects 0.
    popq.delete();
    cfg_parity = 2'b01;
    send_frame(8'h07, 1, 1'b1, 1'b0);
    send_frame(8'h07, 0, 1'b1, 1'b0);
    cfg_parity = 2'b10;
    send_frame(8'h07, 1, 1'b1, 1'b0);
    send_frame(8'h07, 0, 1'b1, 1'b0);
    cfg_parity = 2'b00;
    bit_time(1'b1, 4);
    checks++; if (fifo_count !== 3'd4 || overrun_err !== 1'b0) begin errors++; $display("FAIL par_count got cnt=%0d oe=%b exp 4/0", fifo_count, overrun_err); end
    drain();
    checks++; if (popq.size() !== 4) begin errors++; $display("FAIL par_npop got %0d exp 4", popq.size()); end
    else if (popq[0] !== 9'h007 || popq[1] !== 9'h107 || popq[2] !== 9'h107 || popq[3] !== 9'h007) begin
      errors++; $display("FAIL par_tags got %h %h %h %h exp 007 107 107 007", popq[0], popq[1], popq[2], popq[3]);
    end
  endtask

  task automatic test_overrun();
    popq.delete();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), -1, 1'b1, 1'b0);
    bit_time(1'b1, 4);
    checks++; if (fifo_count !== 3'd4 || overrun_err !== 1'b1) begin errors++; $display("FAIL ovr_set got cnt=%0d oe=%b exp 4/1", fifo_count, overrun_err); end
    checks++; if (rx_data !== 8'h01 || frame_err !== 1'b0) begin errors++; $display("FAIL ovr_head got %h fe=%b exp 01/0", rx_data, frame_err); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL ovr_clr got %b exp 0", overrun_err); end
    send_frame(8'h06, -1, 1'b1, 1'b1);
    rx_ready = 1'b0;
    bit_time(1'b1, 4);
    checks++; if (overrun_err !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL ovr_sixth got oe=%b cnt=%0d exp 0/0", overrun_err, fifo_count); end
    checks++; if (popq.size() !== 5) begin errors++; $display("FAIL ovr_npop got %0d exp 5", popq.size()); end
    else if (popq[0] !== 9'h001 || popq[1] !== 9'h002 || popq[2] !== 9'h003 || popq[3] !== 9'h004 || popq[4] !== 9'h006) begin
      errors++; $display("FAIL ovr_data got %h %h %h %h %h exp 001 002 003 004 006", popq[0], popq[1], popq[2], popq[3], popq[4]);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] d;
    d = 8'hC3;
    popq.delete();
    bit_time(1'b0, CPB);
    for (int i = 0; i < 3; i++) bit_time(d[i], CPB);
    bit_time(d[3], CPB / 2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mrst_busy got %b exp 1", busy); end
    reset = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({busy, rx_valid, rx_data, rx_perr, fifo_count, frame_err, overrun_err} !== 16'h0) begin
      errors++; $display("FAIL mrst_out got busy=%b v=%b d=%h p=%b cnt=%0d fe=%b oe=%b exp all 0", busy, rx_valid, rx_data, rx_perr, fifo_count, frame_err, overrun_err);
    end
    bit_time(1'b1, CPB);
    send_frame(8'h5A, -1, 1'b1, 1'b0);
    bit_time(1'b1, 4);
    checks++; if (fifo_count !== 3'd1 || rx_data !== 8'h5A || rx_perr !== 1'b0) begin errors++; $display("FAIL mrst_next got cnt=%0d d=%h p=%b exp 1/5a/0", fifo_count, rx_data, rx_perr); end
    drain();
  endtask

  initial begin
    reset = 1'b1; rx_in = 1'b1; cfg_parity = 2'b00; rx_ready = 1'b0; err_clr = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_parity();
    test_overrun();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
